// File: rtl/shifter_pkg.sv
// Shared operation encoding for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [2:0] {
    PASS  = 3'd0,
    SLL   = 3'd1,
    SLA   = 3'd2,
    SRL   = 3'd3,
    SRA   = 3'd4,
    ROL   = 3'd5,
    ROR   = 3'd6,
    PASS7 = 3'd7
  } shift_op_t;

endpackage

// File: rtl/shifter_pipe_stage.sv
// One registered barrel-shifter step: shifts by 2**K when amt[K] is set,
// updates carry/ovf, and holds its beat while the next stage stalls.
module shifter_pipe_stage
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  K     = 0,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic [AMT_W-1:0] out_amt,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  // Shift distance of this stage, and whether it is the output stage.
  localparam int S    = 1 << K;
  localparam bit LAST = (K == AMT_W - 1);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] amt_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] data_d;
  logic             carry_d;
  logic             ovf_d;
  logic             zero_d;

  // Bits that must all agree for an arithmetic left shift by S to keep the sign.
  logic [S:0] top_bits;
  assign top_bits = in_data[WIDTH-1 -: S+1];

  // A stage accepts when empty or when its current beat is leaving this cycle.
  assign in_ready = !valid_q || out_ready;

  // Next-state data and flags: inactive stages forward the beat untouched.
  always_comb begin
    data_d  = in_data;
    carry_d = in_carry;
    ovf_d   = in_ovf;
    zero_d  = 1'b0;
    if (in_amt[K]) begin
      case (shift_op_t'(in_op))
        SLL: begin
          data_d  = in_data << S;
          carry_d = in_data[WIDTH-S];
        end
        SLA: begin
          data_d  = in_data << S;
          carry_d = in_data[WIDTH-S];
          ovf_d   = in_ovf | ~((&top_bits) | ~(|top_bits));
        end
        SRL: begin
          data_d  = in_data >> S;
          carry_d = in_data[S-1];
        end
        SRA: begin
          data_d  = $signed(in_data) >>> S;
          carry_d = in_data[S-1];
        end
        ROL: begin
          data_d  = (in_data << S) | (in_data >> (WIDTH - S));
          carry_d = data_d[0];
        end
        ROR: begin
          data_d  = (in_data >> S) | (in_data << (WIDTH - S));
          carry_d = data_d[WIDTH-1];
        end
        default: begin
          data_d  = in_data;
          carry_d = in_carry;
        end
      endcase
    end
    if (LAST) begin
      zero_d = (data_d == '0);
    end
  end

  // Stage register: load on transfer, drop the beat when it leaves, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q  <= data_d;
        op_q    <= in_op;
        amt_q   <= in_amt;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_op    = op_q;
  assign out_amt   = amt_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with valid/ready streaming; one stage per amount bit.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  // Index k is the input of stage k; index AMT_W is the output of the last stage.
  logic [AMT_W:0]   valid_w;
  logic [AMT_W:0]   ready_w;
  logic [WIDTH-1:0] data_w  [AMT_W+1];
  logic [2:0]       op_w    [AMT_W+1];
  logic [AMT_W-1:0] amt_w   [AMT_W+1];
  logic [AMT_W:0]   carry_w;
  logic [AMT_W:0]   ovf_w;
  logic [AMT_W-1:0] zero_w;

  assign valid_w[0]     = in_valid;
  assign data_w[0]      = in_data;
  assign op_w[0]        = in_op;
  assign amt_w[0]       = in_amt;
  assign carry_w[0]     = 1'b0;
  assign ovf_w[0]       = 1'b0;
  assign ready_w[AMT_W] = out_ready;
  assign in_ready       = ready_w[0];

  for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
    shifter_pipe_stage #(
      .WIDTH (WIDTH),
      .K     (gi)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_w[gi]),
      .in_ready  (ready_w[gi]),
      .in_data   (data_w[gi]),
      .in_op     (op_w[gi]),
      .in_amt    (amt_w[gi]),
      .in_carry  (carry_w[gi]),
      .in_ovf    (ovf_w[gi]),
      .out_valid (valid_w[gi+1]),
      .out_ready (ready_w[gi+1]),
      .out_data  (data_w[gi+1]),
      .out_op    (op_w[gi+1]),
      .out_amt   (amt_w[gi+1]),
      .out_carry (carry_w[gi+1]),
      .out_ovf   (ovf_w[gi+1]),
      .out_zero  (zero_w[gi])
    );
  end

  assign out_valid = valid_w[AMT_W];
  assign out_data  = data_w[AMT_W];
  assign out_carry = carry_w[AMT_W];
  assign out_ovf   = ovf_w[AMT_W];
  assign out_zero  = zero_w[AMT_W-1];

  // Op/amt leaving the last stage and zero flags of inner stages have no consumer.
  logic unused_tail;
  assign unused_tail = ^{op_w[AMT_W], amt_w[AMT_W], zero_w[AMT_W-2:0]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench: a bit-by-bit reference model plus scoreboard queue,
// checked every cycle at the falling edge, with directed and random traffic.
module tb_shifter_pipe;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] in_op, in_amt;
  logic       out_carry, out_ovf, out_zero;

  always #5 clk = ~clk;

  shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic [2:0] op;
    logic [2:0] amt;
    int         acc;
    int         stall;
    bit         seen;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_data[$];
  logic       obs_carry[$];
  logic       obs_ovf[$];
  logic       obs_zero[$];
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  int         stall_cnt = 0;
  int         out_count = 0;
  bit         emitted = 0;
  bit         rand_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: shift one bit position at a time; carry is the last bit moved out.
  // Overflow for SLA is the plain signed product leaving the 8-bit range.
  function automatic exp_t model(input logic [7:0] x, input logic [2:0] op, input logic [2:0] amt);
    exp_t       e;
    logic [7:0] r;
    logic       c;
    int         v;
    r = x;
    c = 1'b0;
    for (int i = 0; i < int'(amt); i++) begin
      case (op)
        3'd1, 3'd2: begin c = r[7]; r = {r[6:0], 1'b0}; end
        3'd3:       begin c = r[0]; r = {1'b0, r[7:1]}; end
        3'd4:       begin c = r[0]; r = {r[7], r[7:1]}; end
        3'd5:       begin r = {r[6:0], r[7]}; c = r[0]; end
        3'd6:       begin r = {r[0], r[7:1]}; c = r[7]; end
        default:    ;
      endcase
    end
    e.ovf = 1'b0;
    if (op == 3'd2) begin
      v = int'($signed(x)) * (1 << amt);
      e.ovf = (v > 127) || (v < -128);
    end
    e.data  = r;
    e.carry = c;
    e.zero  = (r == 8'h00);
    e.op    = op;
    e.amt   = amt;
    e.acc   = 0;
    e.stall = 0;
    e.seen  = 0;
    return e;
  endfunction

  // Scoreboard: handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (out_valid) begin
        emitted = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data",  32'(out_data),  32'(exp_q[0].data));
          chk("out_carry", 32'(out_carry), 32'(exp_q[0].carry));
          chk("out_ovf",   32'(out_ovf),   32'(exp_q[0].ovf));
          chk("out_zero",  32'(out_zero),  32'(exp_q[0].zero));
          if (!exp_q[0].seen) begin
            exp_q[0].seen = 1;
            if (stall_cnt == exp_q[0].stall) chk("latency", 32'(cyc - exp_q[0].acc), 32'd3);
            else chk("latency_min", 32'((cyc - exp_q[0].acc) >= 3), 32'd1);
          end
          if (out_ready) begin
            e = exp_q.pop_front();
            obs_data.push_back(out_data);
            obs_carry.push_back(out_carry);
            obs_ovf.push_back(out_ovf);
            obs_zero.push_back(out_zero);
            out_count++;
            $display("beat %0d: op=%0d amt=%0d data=%02h carry=%0b ovf=%0b zero=%0b",
                     out_count, e.op, e.amt, out_data, out_carry, out_ovf, out_zero);
          end
        end
      end else if (!emitted) begin
        chk("idle_data",  32'(out_data),  32'd0);
        chk("idle_flags", 32'({out_carry, out_ovf, out_zero}), 32'd0);
      end
      if (in_valid && in_ready) begin
        e = model(in_data, in_op, in_amt);
        e.acc   = cyc;
        e.stall = stall_cnt;
        exp_q.push_back(e);
      end
    end
    if (!out_ready) stall_cnt++;
  end

  // Random downstream back-pressure while rand_mode is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [2:0] o, input logic [2:0] a);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = o;
    in_amt   = a;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] t1_exp [8] = '{8'h9D, 8'h74, 8'h74, 8'h27, 8'hE7, 8'h76, 8'h67, 8'h9D};

  initial begin
    exp_t m;
    int   base;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_op     = 3'd0;
    in_amt    = 3'd0;
    out_ready = 1'b1;

    // Model pins, hand-computed.
    m = model(8'h9D, 3'd4, 3'd2); chk("pin_sra_9d", 32'(m.data), 32'hE7);
    m = model(8'h81, 3'd3, 3'd1); chk("pin_srl_81", 32'({m.data, m.carry}), 32'({8'h40, 1'b1}));
    m = model(8'h81, 3'd4, 3'd7); chk("pin_sra_81", 32'({m.data, m.carry}), 32'({8'hFF, 1'b0}));
    m = model(8'h81, 3'd1, 3'd7); chk("pin_sll_81", 32'({m.data, m.carry}), 32'({8'h80, 1'b0}));
    m = model(8'hF0, 3'd2, 3'd3); chk("pin_sla_f0", 32'({m.data, m.ovf}), 32'({8'h80, 1'b0}));
    // 0x1F * 4 = 124 still fits a signed byte, so no overflow.
    m = model(8'h1F, 3'd2, 3'd2); chk("pin_sla_1f", 32'({m.data, m.ovf}), 32'({8'h7C, 1'b0}));
    m = model(8'h9D, 3'd2, 3'd2); chk("pin_sla_9d", 32'({m.data, m.ovf}), 32'({8'h74, 1'b1}));
    m = model(8'h01, 3'd3, 3'd1); chk("pin_srl_01", 32'({m.data, m.zero, m.carry}), 32'({8'h00, 1'b1, 1'b1}));

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_flags",     32'({out_carry, out_ovf, out_zero}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: 9D, amt 2, every op back-to-back.
    obs_data.delete(); obs_ovf.delete(); obs_carry.delete();
    for (int i = 0; i < 8; i++) send(8'h9D, 3'(i), 3'd2);
    drain();
    chk("t1_count", 32'(obs_data.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
      chk("t1_data",  32'(obs_data[i]),  32'(t1_exp[i]));
      chk("t1_ovf",   32'(obs_ovf[i]),   32'(i == 2));
      chk("t1_carry", 32'(obs_carry[i]), 32'd0);
    end

    // Tests 2-4: boundary shifts and flags.
    send(8'h81, 3'd3, 3'd1);
    send(8'h81, 3'd4, 3'd7);
    send(8'h81, 3'd1, 3'd7);
    send(8'h1F, 3'd2, 3'd2);
    send(8'hF0, 3'd2, 3'd3);
    send(8'h01, 3'd3, 3'd1);
    send(8'hA5, 3'd5, 3'd0);
    drain();

    // Test 5: fill with out_ready low, hold 5 cycles, then release.
    base = out_count;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h10 + 8'(i), 3'(i), 3'(i));
    chk("t5_in_ready_full", 32'(in_ready),  32'd0);
    chk("t5_out_valid",     32'(out_valid), 32'd1);
    fork
      begin
        for (int i = 3; i < 10; i++) send(8'h10 + 8'(i), 3'(i % 8), 3'((i * 3) % 8));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("t5_in_ready_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_count", 32'(out_count - base), 32'd10);

    // Test 6: reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(8'h3C, 3'd5, 3'(i + 1));
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    emitted = 0;
    #1;
    chk("t6_valid_now", 32'(out_valid), 32'd0);
    chk("t6_data_now",  32'(out_data),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = out_count;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_stale", 32'(out_count - base), 32'd0);
    send(8'hC3, 3'd6, 3'd3);
    drain();
    chk("t6_next_beat", 32'(out_count - base), 32'd1);

    // Random traffic with random back-pressure.
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    rand_mode = 0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
